// File: rtl/seq_arb_pkg.sv
// Shared types and channel constants for the sequence-detector event arbiter.
package seq_arb_pkg;

  localparam int unsigned NUM_CH = 3;

  localparam logic [1:0] CH_W = 2'd0;
  localparam logic [1:0] CH_X = 2'd1;
  localparam logic [1:0] CH_Y = 2'd2;

  typedef enum logic {
    IDLE,
    OFFER
  } arb_state_e;

endpackage

// File: rtl/rr_pick3.sv
// Combinational three-way round-robin picker: search starts one past last_grant, wrapping 2->0.
module rr_pick3
  import seq_arb_pkg::*;
(
  input  logic [NUM_CH-1:0] pending,
  input  logic [1:0]        last_grant,
  output logic [1:0]        winner,
  output logic              any_valid
);

  logic [1:0] first, second, third;

  always_comb begin
    first  = CH_W;
    second = CH_X;
    third  = CH_Y;
    unique case (last_grant)
      CH_W: begin
        first  = CH_X;
        second = CH_Y;
        third  = CH_W;
      end
      CH_X: begin
        first  = CH_Y;
        second = CH_W;
        third  = CH_X;
      end
      default: begin
        first  = CH_W;
        second = CH_X;
        third  = CH_Y;
      end
    endcase
  end

  always_comb begin
    winner    = third;
    any_valid = |pending;
    if (pending[first]) begin
      winner = first;
    end else if (pending[second]) begin
      winner = second;
    end
  end

endmodule

// File: rtl/seq_event_arbiter.sv
// Collects single-cycle hits from three sequence detectors and offers them one at a time
// to a ready/valid consumer in round-robin order, flagging hits lost to overrun.
module seq_event_arbiter
  import seq_arb_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hit_w,
  input  logic              hit_x,
  input  logic              hit_y,
  input  logic [2:0]        en,
  input  logic              evt_ready,
  input  logic              clr_drop,
  output logic              evt_valid,
  output logic [1:0]        evt_id,
  output logic [CNT_W-1:0]  evt_count,
  output logic [2:0]        drop_flag
);

  arb_state_e        state_q, state_d;
  logic [2:0]        pending_q, pending_d;
  logic [1:0]        evt_id_q, evt_id_d;
  logic [1:0]        last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [2:0]        drop_q, drop_d;

  logic [2:0]        hit_vec;
  logic [2:0]        grant_vec;
  logic [2:0]        drop_evt;
  logic [1:0]        winner;
  logic              any_valid;

  assign hit_vec = {hit_y, hit_x, hit_w} & en;

  rr_pick3 u_rr_pick3 (
    .pending    (pending_q),
    .last_grant (last_grant_q),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  always_comb begin
    state_d      = state_q;
    evt_id_d     = evt_id_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    grant_vec    = 3'b000;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d   = OFFER;
          evt_id_d  = winner;
          grant_vec = 3'b001 << winner;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          state_d      = IDLE;
          last_grant_d = evt_id_q;
          count_d      = count_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A hit landing on the bit being granted re-arms it instead of counting as overrun.
    drop_evt  = hit_vec & pending_q & ~grant_vec;
    pending_d = (pending_q & ~grant_vec) | hit_vec;
    drop_d    = (clr_drop ? 3'b000 : drop_q) | drop_evt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pending_q    <= 3'b000;
      evt_id_q     <= CH_W;
      last_grant_q <= CH_Y;
      count_q      <= '0;
      drop_q       <= 3'b000;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      evt_id_q     <= evt_id_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      drop_q       <= drop_d;
    end
  end

  assign evt_valid = (state_q == OFFER);
  assign evt_id    = evt_id_q;
  assign evt_count = count_q;
  assign drop_flag = drop_q;

endmodule

// File: tb/tb_seq_event_arbiter.sv
// Self-checking bench for seq_event_arbiter: directed vector table, corner sequences,
// and randomized traffic against a rule-level reference model.
module tb_seq_event_arbiter;

  logic       clk;
  logic       reset;
  logic       hit_w, hit_x, hit_y;
  logic [2:0] en;
  logic       evt_ready;
  logic       clr_drop;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [7:0] evt_count;
  logic [2:0] drop_flag;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit m_pend [3];
  bit m_drop [3];
  bit m_offer;
  int m_id;
  int m_last;
  int m_cnt;

  seq_event_arbiter #(.CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .hit_w     (hit_w),
    .hit_x     (hit_x),
    .hit_y     (hit_y),
    .en        (en),
    .evt_ready (evt_ready),
    .clr_drop  (clr_drop),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_count (evt_count),
    .drop_flag (drop_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] hit;   // {y, x, w}
    logic [2:0] en;
    logic       rdy;
    logic       clr;
    logic       exp_valid;
    logic [1:0] exp_id;
    int         exp_cnt;
    logic [2:0] exp_drop;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 1'b0;
      m_drop[i] = 1'b0;
    end
    m_offer = 1'b0;
    m_id    = 0;
    m_last  = 2;
    m_cnt   = 0;
  endtask

  // Rules: pick first pending channel after last grant; hits on a pending, ungranted channel drop.
  task automatic model_step(input logic [2:0] hit, input logic [2:0] en_v, input logic rdy,
                            input logic clrd);
    bit granted [3];
    bit h;
    bit found;
    int c;
    found = 1'b0;
    for (int i = 0; i < 3; i++) granted[i] = 1'b0;
    if (!m_offer) begin
      for (int k = 1; k <= 3; k++) begin
        c = (m_last + k) % 3;
        if (!found && m_pend[c]) begin
          found      = 1'b1;
          granted[c] = 1'b1;
          m_id       = c;
          m_offer    = 1'b1;
        end
      end
    end else if (rdy) begin
      m_offer = 1'b0;
      m_last  = m_id;
      m_cnt   = (m_cnt + 1) % 256;
    end
    for (int i = 0; i < 3; i++) begin
      h = hit[i] && en_v[i];
      if (clrd) m_drop[i] = 1'b0;
      if (h && m_pend[i] && !granted[i]) m_drop[i] = 1'b1;
      if (granted[i]) m_pend[i] = 1'b0;
      if (h) m_pend[i] = 1'b1;
    end
  endtask

  task automatic cycle(input logic [2:0] hit, input logic [2:0] en_v, input logic rdy,
                       input logic clrd);
    {hit_y, hit_x, hit_w} = hit;
    en        = en_v;
    evt_ready = rdy;
    clr_drop  = clrd;
    @(posedge clk);
    model_step(hit, en_v, rdy, clrd);
    #1;
    {hit_y, hit_x, hit_w} = 3'b000;
    clr_drop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, 32'(evt_valid), 32'(m_offer));
    chk({tag, ".id"},    32'(evt_id),    32'(m_id));
    chk({tag, ".count"}, 32'(evt_count), 32'(m_cnt));
    chk({tag, ".drop"},  32'(drop_flag), 32'({m_drop[2], m_drop[1], m_drop[0]}));
  endtask

  initial begin
    reset = 1'b0;
    {hit_y, hit_x, hit_w} = 3'b000;
    en        = 3'b111;
    evt_ready = 1'b0;
    clr_drop  = 1'b0;
    model_reset();

    // hit    en      rdy   clr   valid id     cnt drop
    tbl[0]  = '{3'b111, 3'b111, 1'b1, 1'b0, 1'b0, 2'd0, 0, 3'b000};
    tbl[1]  = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b1, 2'd0, 0, 3'b000};
    tbl[2]  = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 2'd0, 1, 3'b000};
    tbl[3]  = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b1, 2'd1, 1, 3'b000};
    tbl[4]  = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 2'd1, 2, 3'b000};
    tbl[5]  = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b1, 2'd2, 2, 3'b000};
    tbl[6]  = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 2'd2, 3, 3'b000};
    tbl[7]  = '{3'b100, 3'b011, 1'b1, 1'b0, 1'b0, 2'd2, 3, 3'b000};
    tbl[8]  = '{3'b000, 3'b011, 1'b1, 1'b0, 1'b0, 2'd2, 3, 3'b000};
    tbl[9]  = '{3'b100, 3'b111, 1'b1, 1'b0, 1'b0, 2'd2, 3, 3'b000};
    tbl[10] = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b1, 2'd2, 3, 3'b000};
    tbl[11] = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 2'd2, 4, 3'b000};
    tbl[12] = '{3'b010, 3'b111, 1'b1, 1'b0, 1'b0, 2'd2, 4, 3'b000};
    tbl[13] = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b1, 2'd1, 4, 3'b000};
    tbl[14] = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 2'd1, 5, 3'b000};

    // Reset state
    do_reset();
    chk("rst.valid", 32'(evt_valid), 32'd0);
    chk("rst.id",    32'(evt_id),    32'd0);
    chk("rst.count", 32'(evt_count), 32'd0);
    chk("rst.drop",  32'(drop_flag), 32'd0);

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].hit, tbl[i].en, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d.valid", i), 32'(evt_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d.id", i),    32'(evt_id),    32'(tbl[i].exp_id));
      chk($sformatf("tbl%0d.count", i), 32'(evt_count), 32'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d.drop", i),  32'(drop_flag), 32'(tbl[i].exp_drop));
    end

    // Single hit_x from reset: offered one cycle after the hit edge, counted on accept
    do_reset();
    cycle(3'b010, 3'b111, 1'b1, 1'b0);
    chk("x.pend_valid", 32'(evt_valid), 32'd0);
    cycle(3'b000, 3'b111, 1'b1, 1'b0);
    chk("x.valid", 32'(evt_valid), 32'd1);
    chk("x.id",    32'(evt_id),    32'd1);
    cycle(3'b000, 3'b111, 1'b1, 1'b0);
    chk("x.count", 32'(evt_count), 32'd1);
    chk("x.done",  32'(evt_valid), 32'd0);

    // Stalled offer of y: rearm, then overrun, then clear and clear-vs-drop collision
    do_reset();
    cycle(3'b100, 3'b111, 1'b0, 1'b0);
    cycle(3'b000, 3'b111, 1'b0, 1'b0);
    chk("stall.valid", 32'(evt_valid), 32'd1);
    chk("stall.id",    32'(evt_id),    32'd2);
    cycle(3'b100, 3'b111, 1'b0, 1'b0);
    chk("stall.rearm_drop", 32'(drop_flag), 32'd0);
    cycle(3'b100, 3'b111, 1'b0, 1'b0);
    chk("stall.overrun", 32'(drop_flag), 32'b100);
    cycle(3'b000, 3'b111, 1'b0, 1'b0);
    chk("stall.hold_id",    32'(evt_id),    32'd2);
    chk("stall.hold_valid", 32'(evt_valid), 32'd1);
    chk("stall.hold_count", 32'(evt_count), 32'd0);
    cycle(3'b000, 3'b111, 1'b0, 1'b1);
    chk("stall.clr", 32'(drop_flag), 32'd0);
    cycle(3'b100, 3'b111, 1'b0, 1'b1);
    chk("stall.clr_vs_drop", 32'(drop_flag), 32'b100);
    cycle(3'b000, 3'b111, 1'b1, 1'b0);
    chk("stall.accept", 32'(evt_count), 32'd1);
    cycle(3'b000, 3'b111, 1'b1, 1'b0);
    chk("stall.reoffer_id", 32'(evt_id), 32'd2);
    chk("stall.reoffer_v",  32'(evt_valid), 32'd1);

    // Reset during OFFER discards the event immediately
    do_reset();
    cycle(3'b010, 3'b111, 1'b0, 1'b0);
    cycle(3'b000, 3'b111, 1'b0, 1'b0);
    chk("rstoff.pre_valid", 32'(evt_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstoff.valid", 32'(evt_valid), 32'd0);
    chk("rstoff.count", 32'(evt_count), 32'd0);
    chk("rstoff.id",    32'(evt_id),    32'd0);
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    cycle(3'b000, 3'b111, 1'b1, 1'b0);
    chk("rstoff.after", 32'(evt_valid), 32'd0);

    // Counter wrap after 256 accepted events
    do_reset();
    for (int i = 0; i < 256; i++) begin
      cycle(3'b001, 3'b111, 1'b1, 1'b0);
      cycle(3'b000, 3'b111, 1'b1, 1'b0);
      cycle(3'b000, 3'b111, 1'b1, 1'b0);
      if (i == 254) chk("wrap.255", 32'(evt_count), 32'd255);
    end
    chk("wrap.zero", 32'(evt_count), 32'd0);
    chk("wrap.drop", 32'(drop_flag), 32'd0);

    // Randomized traffic against the reference model
    do_reset();
    begin
      logic [2:0] rh, ren;
      logic       rr, rc;
      ren = 3'b111;
      for (int i = 0; i < 3000; i++) begin
        rh = 3'b000;
        for (int b = 0; b < 3; b++) rh[b] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 15) == 0) ren = 3'($urandom_range(0, 7));
        rr = ($urandom_range(0, 2) != 0);
        rc = ($urandom_range(0, 15) == 0);
        cycle(rh, ren, rr, rc);
        chk_model($sformatf("rand%0d", i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
